// File: rtl/down_counter_pkg.sv
// rtl/down_counter_pkg.sv - shared counter width and constants for down_counter_5bit
package down_counter_pkg;

  localparam int CNT_W = 5;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

endpackage

// File: rtl/down_counter_5bit.sv
// rtl/down_counter_5bit.sv - loadable saturating down counter with done pulse
// Optional simulation checks: define DOWN_COUNTER_5BIT_ASSERT_EN.
module down_counter_5bit
  import down_counter_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic [CNT_W-1:0] count,
  input  logic             Load,
  output logic [CNT_W-1:0] Q,
  output logic             shift_enable,
  output logic             done
);

  // Reset beats Load beats decrement; done only marks a 1->0 decrement.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Q    <= CNT_ZERO;
      done <= 1'b0;
    end else if (Load) begin
      Q    <= count;
      done <= 1'b0;
    end else if (Q != CNT_ZERO) begin
      Q    <= Q - CNT_ONE;
      done <= (Q == CNT_ONE);
    end else begin
      done <= 1'b0;
    end
  end

  assign shift_enable = (Q != CNT_ZERO);

`ifdef DOWN_COUNTER_5BIT_ASSERT_EN
  logic seen_reset;

  always_ff @(posedge Clk) begin
    if (Reset) seen_reset <= 1'b1;
  end

  wire armed = (seen_reset === 1'b1);

  a_no_increase: assert property (@(posedge Clk)
    ($past(armed) && !$past(Reset) && !$past(Load)) |-> (Q <= $past(Q)));

  a_no_wrap: assert property (@(posedge Clk)
    ($past(armed) && !$past(Reset) && !$past(Load)) |-> !(($past(Q) == CNT_ZERO) && (Q == {CNT_W{1'b1}})));

  a_shift_enable: assert property (@(posedge Clk)
    armed |-> (shift_enable == (Q != CNT_ZERO)));

  a_done_single: assert property (@(posedge Clk)
    (armed && done) |=> !done);

  a_no_x: assert property (@(posedge Clk)
    armed |-> !$isunknown({Q, shift_enable, done}));
`else
`endif

endmodule

// File: tb/tb_down_counter_5bit.sv
// tb/tb_down_counter_5bit.sv - randomized self-checking bench for down_counter_5bit
module tb_down_counter_5bit;

  logic       Clk;
  logic       Reset;
  logic [4:0] count;
  logic       Load;
  logic [4:0] Q;
  logic       shift_enable;
  logic       done;

  int n_checks;
  int n_pass;
  int m_q;
  bit m_done;
  int se_cnt;
  int done_cnt;

  down_counter_5bit dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .count        (count),
    .Load         (Load),
    .Q            (Q),
    .shift_enable (shift_enable),
    .done         (done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    else
      n_pass++;
  endtask

  // Reference: the counter is "cycles of shifting left"; done marks the cycle
  // right after the last remaining shift was consumed by a plain decrement.
  task automatic step(input bit r, input bit l, input logic [4:0] c);
    Reset = r;
    Load  = l;
    count = c;
    @(posedge Clk);
    if (r) begin
      m_q = 0;
      m_done = 0;
    end else if (l) begin
      m_q = int'(c);
      m_done = 0;
    end else if (m_q > 0) begin
      m_q = m_q - 1;
      m_done = (m_q == 0);
    end else begin
      m_done = 0;
    end
    #1;
    check("q", 32'(Q), 32'(m_q));
    check("shift_enable", 32'(shift_enable), 32'(m_q != 0));
    check("done", 32'(done), 32'(m_done));
    if (shift_enable === 1'b1) se_cnt++;
    if (done === 1'b1) done_cnt++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    m_q      = 0;
    m_done   = 0;
    Reset    = 1'b0;
    Load     = 1'b0;
    count    = '0;

    // Reset overrides a concurrent load
    step(1, 1, 5'd7);
    step(1, 1, 5'd7);
    check("reset_q", 32'(Q), 32'd0);
    check("reset_done", 32'(done), 32'd0);

    // Load 7 then free-run
    se_cnt = 0; done_cnt = 0;
    step(0, 1, 5'd7);
    check("load7_q", 32'(Q), 32'd7);
    for (int i = 0; i < 10; i++) step(0, 0, 5'($urandom));
    check("load7_se_cycles", 32'(se_cnt), 32'd7);
    check("load7_done_pulses", 32'(done_cnt), 32'd1);

    // Load 0: no pulse, no wrap
    se_cnt = 0; done_cnt = 0;
    step(0, 1, 5'd0);
    for (int i = 0; i < 5; i++) step(0, 0, 5'($urandom));
    check("load0_q", 32'(Q), 32'd0);
    check("load0_done_pulses", 32'(done_cnt), 32'd0);
    check("load0_se_cycles", 32'(se_cnt), 32'd0);

    // Load 31: full range
    se_cnt = 0; done_cnt = 0;
    step(0, 1, 5'd31);
    for (int i = 0; i < 35; i++) step(0, 0, 5'($urandom));
    check("load31_se_cycles", 32'(se_cnt), 32'd31);
    check("load31_done_pulses", 32'(done_cnt), 32'd1);
    check("load31_q", 32'(Q), 32'd0);

    // Mid-count reload abandons the first count
    se_cnt = 0; done_cnt = 0;
    step(0, 1, 5'd5);
    step(0, 0, 5'd0);
    step(0, 0, 5'd0);
    check("mid_before_q", 32'(Q), 32'd3);
    step(0, 1, 5'd2);
    check("mid_after_q", 32'(Q), 32'd2);
    for (int i = 0; i < 4; i++) step(0, 0, 5'd0);
    check("mid_done_pulses", 32'(done_cnt), 32'd1);

    // Load wins over the final decrement
    step(0, 1, 5'd1);
    step(0, 1, 5'd4);
    check("conflict_load_q", 32'(Q), 32'd4);
    check("conflict_load_done", 32'(done), 32'd0);

    // Reset wins over load mid-count
    step(0, 1, 5'd3);
    step(1, 1, 5'd9);
    check("conflict_reset_q", 32'(Q), 32'd0);

    // Random traffic, biased toward short counts so done pulses are frequent
    for (int i = 0; i < 3000; i++) begin
      bit r, l;
      logic [4:0] c;
      r = ($urandom_range(0, 63) == 0);
      l = ($urandom_range(0, 7) == 0);
      c = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 4)) : 5'($urandom);
      step(r, l, c);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
